// File: rtl/conv_pool_rx.sv
// Receive side of the conv engine: 2x2 stride-2 max pooling over one FM x FM raster map.
// Optional macro POOL_RELU_EN fuses a ReLU into each window result.
module conv_pool_rx #(
    parameter int FM = 12,
    parameter int DW = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_en,
    input  logic                 in_done,
    output logic signed [DW-1:0] out,
    output logic                 out_en,
    output logic                 done,
    output logic                 err
);

    localparam int CW = $clog2(FM);
    localparam int HF = FM / 2;
    localparam int HW = (HF > 1) ? $clog2(HF) : 1;
    localparam int NW = $clog2(HF * HF + 1);
    localparam logic [CW-1:0] LAST = CW'(FM - 1);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_FIN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic signed [DW-1:0] max_signed(input logic signed [DW-1:0] a,
                                                        input logic signed [DW-1:0] b);
        max_signed = (a > b) ? a : b;
    endfunction

    function automatic logic signed [DW-1:0] pool_out(input logic signed [DW-1:0] m);
`ifdef POOL_RELU_EN
        pool_out = max_signed(m, {DW{1'b0}});
`else
        pool_out = m;
`endif
    endfunction

    logic [1:0]           state_r;
    logic [CW-1:0]        col_r;
    logic [CW-1:0]        row_r;
    logic [NW-1:0]        out_cnt_r;
    logic signed [DW-1:0] pmax_r;
    logic signed [DW-1:0] rowbuf_r [HF];

    logic [HW-1:0]        idx_s;
    logic signed [DW-1:0] p_s;
    logic signed [DW-1:0] win_s;
    logic                 last_s;
    logic                 take_s;

    assign idx_s  = HW'(col_r >> 1);
    assign p_s    = max_signed(pmax_r, in_data);
    assign win_s  = pool_out(max_signed(rowbuf_r[idx_s], p_s));
    assign last_s = (row_r == LAST) && (col_r == LAST);
    assign take_s = (state_r == S_RUN) && in_en;

    // Half-row buffer: horizontal pair maxima of the even row, read back on the odd row.
    always_ff @(posedge clk) begin
        if (!rst && take_s && col_r[0] && !row_r[0]) begin
            rowbuf_r[idx_s] <= p_s;
        end
    end

    // Control FSM, raster counters and registered pooled outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_RUN;
            col_r     <= {CW{1'b0}};
            row_r     <= {CW{1'b0}};
            out_cnt_r <= {NW{1'b0}};
            pmax_r    <= {DW{1'b0}};
            out       <= {DW{1'b0}};
            out_en    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_en <= 1'b0;
            case (state_r)
                S_RUN: begin
                    if (in_en) begin
                        if (!col_r[0]) begin
                            pmax_r <= in_data;
                        end else if (row_r[0]) begin
                            out       <= win_s;
                            out_en    <= 1'b1;
                            out_cnt_r <= out_cnt_r + NW'(1);
                        end
                        if (col_r == LAST) begin
                            col_r <= {CW{1'b0}};
                            row_r <= (row_r == LAST) ? {CW{1'b0}} : row_r + CW'(1);
                        end else begin
                            col_r <= col_r + CW'(1);
                        end
                    end
                    // Final sample wins over a simultaneous in_done; done rises with the last strobe.
                    if (in_en && last_s) begin
                        state_r <= S_FIN;
                        done    <= 1'b1;
                    end else if (in_done) begin
                        state_r <= S_DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end
                end
                S_FIN: begin
                    state_r <= S_DONE;
                    if (in_en) begin
                        err <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (in_en) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_DONE;
                    done    <= 1'b1;
                    err     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pool_rx.sv
// Table-driven bench for conv_pool_rx: whole-map scenarios checked against a 2D pooling model.
module tb_conv_pool_rx;

    localparam int FM = 12;
    localparam int DW = 13;
    localparam int HF = FM / 2;
    localparam int NS = FM * FM;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] in_data;
    logic                 in_en;
    logic                 in_done;
    logic signed [DW-1:0] out;
    logic                 out_en;
    logic                 done;
    logic                 err;

    always #5 clk = ~clk;

    conv_pool_rx #(.FM(FM), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en), .in_done(in_done),
        .out(out), .out_en(out_en), .done(done), .err(err)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_got = 0;
    int got_val [512];
    int got_cyc [512];
    logic got_done [512];
    int drive_cyc [NS];
    logic ab_pre, ab_err, ab_done, pre_extra_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output strobe with its cycle and the done flag seen alongside it.
    always @(negedge clk) begin
        if (out_en && n_got < 512) begin
            got_val[n_got]  = int'(out);
            got_cyc[n_got]  = cyc;
            got_done[n_got] = done;
            n_got = n_got + 1;
        end
    end

    typedef struct {
        int   pat;
        int   gap;
        int   nsamp;
        int   done_at;
        int   extra;
        int   exp_cnt;
        logic exp_err;
        logic abort;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int sample(input int pat, input int r, input int c);
        case (pat)
            0: sample = r * FM + c;
            1: sample = ((r == 0 && c == 0) || (r == 2 && c == 3) ||
                         (r == 5 && c == 4) || (r == 7 && c == 7)) ? 500 : -7;
            2: sample = -5;
            default: sample = 0;
        endcase
    endfunction

    function automatic int model(input int pat, input int wr, input int wc);
        int m;
        m = sample(pat, 2 * wr, 2 * wc);
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (sample(pat, 2 * wr + dr, 2 * wc + dc) > m) m = sample(pat, 2 * wr + dr, 2 * wc + dc);
`ifdef POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        model = m;
    endfunction

    task automatic do_reset();
        in_en = 1'b0; in_done = 1'b0; in_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_map(input int pat, input int gap, input int nsamp, input int done_at);
        @(posedge clk); #1;
        for (int k = 0; k < nsamp; k++) begin
            in_data = DW'(sample(pat, k / FM, k % FM));
            in_en   = 1'b1;
            in_done = (k + 1 == done_at);
            drive_cyc[k] = cyc;
            if (k + 1 == done_at) ab_pre = err;
            @(posedge clk); #1;
            if (k + 1 == done_at) begin ab_err = err; ab_done = done; end
            in_en = 1'b0; in_done = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drive_extra(input int extra);
        repeat (2) begin @(posedge clk); #1; end
        pre_extra_err = err;
        for (int k = 0; k < extra; k++) begin
            in_en = 1'b1; in_data = DW'(77);
            @(posedge clk); #1;
            in_en = 1'b0;
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic check_map(input string tag, input int base, input int pat, input int exp_cnt,
                             input logic exp_err, input logic abort);
        int cnt, wr, wc;
        cnt = n_got - base;
        check({tag, " pulses"}, cnt, exp_cnt);
        for (int i = 0; i < cnt && i < exp_cnt; i++) begin
            wr = i / HF; wc = i % HF;
            check($sformatf("%s out[%0d]", tag, i), got_val[base + i], model(pat, wr, wc));
            check($sformatf("%s cyc[%0d]", tag, i), got_cyc[base + i],
                  drive_cyc[(2 * wr + 1) * FM + 2 * wc + 1] + 1);
        end
        if (!abort && cnt == exp_cnt && cnt > 1) begin
            check({tag, " done@last"}, int'(got_done[base + cnt - 1]), 1);
            check({tag, " done@prev"}, int'(got_done[base + cnt - 2]), 0);
        end
        check({tag, " err"}, int'(err), int'(exp_err));
        check({tag, " done"}, int'(done), 1);
    endtask

    vec_t vecs [6];
    int base;

    initial begin
        vecs[0] = '{pat: 0, gap: 6, nsamp: NS,  done_at: NS,  extra: 0, exp_cnt: 36, exp_err: 1'b0, abort: 1'b0};
        vecs[1] = '{pat: 0, gap: 0, nsamp: NS,  done_at: NS,  extra: 0, exp_cnt: 36, exp_err: 1'b0, abort: 1'b0};
        vecs[2] = '{pat: 1, gap: 0, nsamp: NS,  done_at: 0,   extra: 0, exp_cnt: 36, exp_err: 1'b0, abort: 1'b0};
        vecs[3] = '{pat: 2, gap: 1, nsamp: NS,  done_at: NS,  extra: 0, exp_cnt: 36, exp_err: 1'b0, abort: 1'b0};
        vecs[4] = '{pat: 0, gap: 0, nsamp: 100, done_at: 100, extra: 5, exp_cnt: 24, exp_err: 1'b1, abort: 1'b1};
        vecs[5] = '{pat: 0, gap: 0, nsamp: NS,  done_at: NS,  extra: 1, exp_cnt: 36, exp_err: 1'b1, abort: 1'b0};

        do_reset();
        check("reset out", int'(out), 0);
        check("reset out_en", int'(out_en), 0);
        check("reset done", int'(done), 0);
        check("reset err", int'(err), 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            base = n_got;
            run_map(vecs[v].pat, vecs[v].gap, vecs[v].nsamp, vecs[v].done_at);
            if (vecs[v].abort) begin
                check($sformatf("v%0d err before abort", v), int'(ab_pre), 0);
                check($sformatf("v%0d err after abort", v), int'(ab_err), 1);
                check($sformatf("v%0d done after abort", v), int'(ab_done), 1);
            end
            drive_extra(vecs[v].extra);
            if (vecs[v].extra > 0)
                check($sformatf("v%0d err before extra", v), int'(pre_extra_err), int'(vecs[v].abort));
            check_map($sformatf("v%0d", v), base, vecs[v].pat, vecs[v].exp_cnt,
                      vecs[v].exp_err, vecs[v].abort);
        end

        // Reset in the middle of a map, then a clean full ramp.
        do_reset();
        run_map(0, 0, 50, 0);
        check("mid pulses before rst", n_got - base, 36 + 12);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid rst out", int'(out), 0);
        check("mid rst out_en", int'(out_en), 0);
        check("mid rst done", int'(done), 0);
        check("mid rst err", int'(err), 0);
        base = n_got;
        run_map(0, 6, NS, NS);
        drive_extra(0);
        check_map("mid", base, 0, 36, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
